fetch_branch_predictor: RTL and testbench
=========================================

// Module: fetch_branch_predictor
// PURPOSE
//  Fetch-stage next-PC predictor: direct-mapped BTB plus per-entry 2-bit counter.
//  Looks up pc_F each cycle and produces next_pc_F, and pipelines the prediction into D.
//  Retrains from E using the Execute-stage mispredict flag and the hysteresis next-counter value.
//  Overrides fetch with the corrected PC on an E-stage mispredict.
// PARAMETERS
//  BTB_ENTRIES  64  entry count; power of two, >=4
//  IDX_BITS     $clog2(BTB_ENTRIES)  derived; do not override
//  TAG_BITS     30-IDX_BITS  derived; do not override
//  CNT_W        32  width of perf counters
// PORTS
//  clk            in   1      clock, rising edge
//  rst_l          in   1      asynchronous, active-low reset
//  pc_F           in   32     current fetch PC
//  stall_F        in   1      hold F->D prediction register
//  flush_D        in   1      clear D prediction register (bubble)
//  next_pc_F      out  32     PC to fetch next cycle
//  pred_taken_D   out  1      D-stage copy of prediction, travels to E
//  pred_ctr_D     out  2      D-stage copy of looked-up counter (curr for E update)
//  upd_valid_E    in   1      E holds a valid, non-squashed instruction
//  opcode_E       in   opcode_t   E-stage opcode
//  pc_E           in   32     E-stage PC
//  target_addr_E  in   32     resolved target
//  br_cond_E      in   1      branch condition outcome
//  mispredict_E   in   1      E-stage mispredict flag
//  ctr_next_E     in   2      next counter value from the hysteresis counter
//  n_ctrl_E       out  CNT_W  control instructions updated
//  n_mispred_E    out  CNT_W  mispredicts seen
// BEHAVIOUR
//  Index = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2]. pc[1:0] ignored.
//  Entry = {valid, tag, target[31:0], ctr[1:0]}.
//  Lookup (comb): hit = valid && tag match. pred_taken = hit && ctr[1].
//   pred_target = entry.target.
//  next_pc_F priority:
//   1. upd_valid_E && mispredict_E:
//      (opcode_E in {JAL,JALR} || br_cond_E) ? target_addr_E : pc_E+4.
//   2. pred_taken: pred_target.
//   3. pc_F+4.
//   Arithmetic is mod 2^32; wrap allowed.
//  D register {pred_taken_D, pred_ctr_D} has 1-cycle latency.
//   flush_D or a priority-1 redirect loads {0, 2'b00}. This has precedence over stall_F.
//   Otherwise stall_F holds the register.
//   Otherwise it loads {pred_taken, hit ? ctr : 2'b00}.
//  Update (posedge, upd_valid_E only, opcode_E in {BRANCH,JAL,JALR}):
//   - entry at pc_E index hits: write ctr <= ctr_next_E. Write target <= target_addr_E
//     when taken (JAL/JALR or br_cond_E).
//   - miss and taken: allocate/replace. valid=1, tag, target=target_addr_E, ctr=ctr_next_E.
//   - miss and not-taken branch: no write.
//   - other opcodes: no write; perf counters unchanged.
//  Same-cycle lookup/update of the same index: lookup sees the OLD entry (no bypass).
//  Perf: n_ctrl_E +1 per qualifying update; n_mispred_E +1 when mispredict_E also set.
//   Both saturate at all-ones.
//  Reset (rst_l low, async): all valid=0, D reg={0,00}, perf counters=0.
//   next_pc_F = pc_F+4 immediately. Target/tag arrays need not be reset.
//   Reset mid-update: the write is lost and the entry is left invalid.
// STRUCTURE
//  Shared package: btb_entry_t struct, BTB_ENTRIES default, CTR_STRONG_TAKE/WEAK/...
//   encodings shared with the hysteresis counter.
//  opcode_t comes from RISCV_ISA.
//  One sub-module: btb_array (storage, async valid clear, 1 write port, 1 comb read port).
//  Top holds next-PC mux, D register, update control and perf counters.
// TESTING
//  1. After reset, pc_F=0x100 -> next_pc_F=0x104; pred_taken_D=0 next cycle.
//  2. JAL at pc_E=0x200, target 0x400, mispredict_E=1, ctr_next_E=11
//     -> next_pc_F=0x400 that cycle. Later pc_F=0x200 -> next_pc_F=0x400, pred_ctr_D=11.
//  3. Not-taken branch miss at 0x300, br_cond_E=0, ctr_next_E=00 -> no allocate.
//     Later pc_F=0x300 -> next_pc_F=0x304.
//  4. Entry 0x500 ctr=11 -> branch resolves not-taken, mispredict_E=1, ctr_next_E=10
//     -> next_pc_F=pc_E+4, D reg cleared. Lookup still predicts taken (ctr=10).
//  5. Aliasing: pc 0x000 and 0x000+4*BTB_ENTRIES, same index.
//     Second allocation evicts the first; first now misses.
//  6. Same-cycle update/lookup of the same index returns old data.
//     stall_F holds D reg; flush_D during stall_F clears it; perf counters saturate.

Source files
------------

// File: rtl/fetch_branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// fetch_branch_predictor_pkg : BTB entry layout, counter encodings, opcodes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_branch_predictor_pkg;

  localparam int BTB_ENTRIES_DEF = 64;
  // Widest tag any legal BTB size needs (4 entries -> 28 tag bits).
  localparam int TAG_W_MAX       = 28;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  // RV32I major opcodes.
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

  function automatic logic ctr_taken(input logic [1:0] ctr);
    return ctr[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_branch_predictor_btb_array.sv
// ---------------------------------------------------------------------------
// fetch_branch_predictor_btb_array : direct-mapped BTB storage, 1W / 1R + tag probe
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_branch_predictor_btb_array
  import fetch_branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES_DEF
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic [$clog2(ENTRIES)-1:0]     rd_idx_i,
  output btb_entry_t                     rd_entry_o,
  input  logic [$clog2(ENTRIES)-1:0]     probe_idx_i,
  output logic                           probe_valid_o,
  output logic [30-$clog2(ENTRIES)-1:0]  probe_tag_o,
  input  logic                           wr_en_i,
  input  logic                           wr_ctr_only_i,
  input  logic [$clog2(ENTRIES)-1:0]     wr_idx_i,
  input  logic [30-$clog2(ENTRIES)-1:0]  wr_tag_i,
  input  logic [31:0]                    wr_target_i,
  input  logic [1:0]                     wr_ctr_i
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid_q <= '0;
    end else if (wr_en_i && !wr_ctr_only_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; an entry is only trusted once valid is set.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      ctr_q[wr_idx_i] <= wr_ctr_i;
      if (!wr_ctr_only_i) begin
        tag_q[wr_idx_i]    <= wr_tag_i;
        target_q[wr_idx_i] <= wr_target_i;
      end
    end
  end

  always_comb begin
    rd_entry_o.valid  = valid_q[rd_idx_i];
    rd_entry_o.tag    = TAG_W_MAX'(tag_q[rd_idx_i]);
    rd_entry_o.target = target_q[rd_idx_i];
    rd_entry_o.ctr    = ctr_q[rd_idx_i];
  end

  assign probe_valid_o = valid_q[probe_idx_i];
  assign probe_tag_o   = tag_q[probe_idx_i];

endmodule

`default_nettype wire

// File: rtl/fetch_branch_predictor.sv
// ---------------------------------------------------------------------------
// fetch_branch_predictor : BTB + 2-bit counter next-PC predictor with E-stage retrain
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_branch_predictor
  import fetch_branch_predictor_pkg::*;
#(
  parameter int BTB_ENTRIES = BTB_ENTRIES_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [31:0]      pc_F,
  input  logic             stall_F,
  input  logic             flush_D,
  output logic [31:0]      next_pc_F,
  output logic             pred_taken_D,
  output logic [1:0]       pred_ctr_D,
  input  logic             upd_valid_E,
  input  opcode_t          opcode_E,
  input  logic [31:0]      pc_E,
  input  logic [31:0]      target_addr_E,
  input  logic             br_cond_E,
  input  logic             mispredict_E,
  input  logic [1:0]       ctr_next_E,
  output logic [CNT_W-1:0] n_ctrl_E,
  output logic [CNT_W-1:0] n_mispred_E
);

  localparam int IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;

  logic [IDX_BITS-1:0] w_idx_F, w_idx_E;
  logic [TAG_BITS-1:0] w_tag_F, w_tag_E, w_probe_tag;
  btb_entry_t          w_rd;
  logic                w_probe_valid;
  logic                w_hit_F, w_hit_E, w_pred_taken;
  logic                w_is_jump, w_is_ctrl, w_taken_E, w_upd, w_redirect;
  logic                w_wr_en, w_wr_ctr_only;
  logic                w_unused;

  logic                pred_taken_q, pred_taken_d;
  logic [1:0]          pred_ctr_q, pred_ctr_d;
  logic [CNT_W-1:0]    n_ctrl_q, n_ctrl_d, n_mispred_q, n_mispred_d;

  assign w_idx_F = pc_F[IDX_BITS+1:2];
  assign w_tag_F = pc_F[31:IDX_BITS+2];
  assign w_idx_E = pc_E[IDX_BITS+1:2];
  assign w_tag_E = pc_E[31:IDX_BITS+2];
  assign w_unused = ^{pc_F[1:0], pc_E[1:0]};

  fetch_branch_predictor_btb_array #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst_l         (rst_l),
    .rd_idx_i      (w_idx_F),
    .rd_entry_o    (w_rd),
    .probe_idx_i   (w_idx_E),
    .probe_valid_o (w_probe_valid),
    .probe_tag_o   (w_probe_tag),
    .wr_en_i       (w_wr_en),
    .wr_ctr_only_i (w_wr_ctr_only),
    .wr_idx_i      (w_idx_E),
    .wr_tag_i      (w_tag_E),
    .wr_target_i   (target_addr_E),
    .wr_ctr_i      (ctr_next_E)
  );

  assign w_hit_F      = w_rd.valid && (w_rd.tag == TAG_W_MAX'(w_tag_F));
  assign w_pred_taken = w_hit_F && ctr_taken(w_rd.ctr);

  assign w_is_jump  = (opcode_E == OP_JAL) || (opcode_E == OP_JALR);
  assign w_is_ctrl  = w_is_jump || (opcode_E == OP_BRANCH);
  assign w_taken_E  = w_is_jump || br_cond_E;
  assign w_upd      = upd_valid_E && w_is_ctrl;
  // Redirect is suppressed while in reset so fetch falls through to pc_F+4.
  assign w_redirect = rst_l && upd_valid_E && mispredict_E;
  assign w_hit_E    = w_probe_valid && (w_probe_tag == w_tag_E);

  // Taken outcomes write the whole entry (allocate or refresh); not-taken hits retrain ctr only.
  assign w_wr_en       = w_upd && (w_taken_E || w_hit_E);
  assign w_wr_ctr_only = !w_taken_E;

  always_comb begin
    next_pc_F = pc_F + 32'd4;
    if (w_redirect) begin
      next_pc_F = w_taken_E ? target_addr_E : (pc_E + 32'd4);
    end else if (w_pred_taken) begin
      next_pc_F = w_rd.target;
    end
  end

  always_comb begin
    pred_taken_d = pred_taken_q;
    pred_ctr_d   = pred_ctr_q;
    if (flush_D || w_redirect) begin
      pred_taken_d = 1'b0;
      pred_ctr_d   = CTR_STRONG_NT;
    end else if (!stall_F) begin
      pred_taken_d = w_pred_taken;
      pred_ctr_d   = w_hit_F ? w_rd.ctr : CTR_STRONG_NT;
    end
  end

  always_comb begin
    n_ctrl_d    = n_ctrl_q;
    n_mispred_d = n_mispred_q;
    if (w_upd && (n_ctrl_q != '1)) begin
      n_ctrl_d = n_ctrl_q + CNT_W'(1);
    end
    if (w_upd && mispredict_E && (n_mispred_q != '1)) begin
      n_mispred_d = n_mispred_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pred_taken_q <= 1'b0;
      pred_ctr_q   <= CTR_STRONG_NT;
      n_ctrl_q     <= '0;
      n_mispred_q  <= '0;
    end else begin
      pred_taken_q <= pred_taken_d;
      pred_ctr_q   <= pred_ctr_d;
      n_ctrl_q     <= n_ctrl_d;
      n_mispred_q  <= n_mispred_d;
    end
  end

  assign pred_taken_D = pred_taken_q;
  assign pred_ctr_D   = pred_ctr_q;
  assign n_ctrl_E     = n_ctrl_q;
  assign n_mispred_E  = n_mispred_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_fetch_branch_predictor : directed vectors, cycle-tagged scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_branch_predictor;
  import fetch_branch_predictor_pkg::*;

  localparam int S_NPC  = 0;
  localparam int S_TAKD = 1;
  localparam int S_CTRD = 2;
  localparam int S_CTRL = 3;
  localparam int S_MIS  = 4;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [31:0] pc_F, pc_E, target_addr_E, next_pc_F;
  logic        stall_F, flush_D, upd_valid_E, br_cond_E, mispredict_E;
  logic [1:0]  ctr_next_E, pred_ctr_D;
  logic        pred_taken_D;
  opcode_t     opcode_E;
  logic [3:0]  n_ctrl_E, n_mispred_E;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t sbq[$];

  fetch_branch_predictor #(
    .BTB_ENTRIES (64),
    .CNT_W       (4)
  ) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .pc_F          (pc_F),
    .stall_F       (stall_F),
    .flush_D       (flush_D),
    .next_pc_F     (next_pc_F),
    .pred_taken_D  (pred_taken_D),
    .pred_ctr_D    (pred_ctr_D),
    .upd_valid_E   (upd_valid_E),
    .opcode_E      (opcode_E),
    .pc_E          (pc_E),
    .target_addr_E (target_addr_E),
    .br_cond_E     (br_cond_E),
    .mispredict_E  (mispredict_E),
    .ctr_next_E    (ctr_next_E),
    .n_ctrl_E      (n_ctrl_E),
    .n_mispred_E   (n_mispred_E)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int s);
    case (s)
      S_NPC:   return next_pc_F;
      S_TAKD:  return {31'b0, pred_taken_D};
      S_CTRD:  return {30'b0, pred_ctr_D};
      S_CTRL:  return {28'b0, n_ctrl_E};
      default: return {28'b0, n_mispred_E};
    endcase
  endfunction

  // Monitor: every expectation tagged with this cycle is compared mid-cycle.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: expectation for cycle %0d never sampled, required 0x%0h",
                 sbq[i].name, sbq[i].cyc, sbq[i].exp);
        sbq.delete(i);
      end else if (sbq[i].cyc == cyc) begin
        checks++;
        if (actual(sbq[i].sig) !== sbq[i].exp) begin
          failures++;
          $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)",
                   sbq[i].name, actual(sbq[i].sig), sbq[i].exp, cyc);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic exp_now(input int s, input logic [31:0] v, input string n);
    sbq.push_back('{cyc, s, v, n});
  endtask

  task automatic exp_next(input int s, input logic [31:0] v, input string n);
    sbq.push_back('{cyc + 1, s, v, n});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    upd_valid_E  = 1'b0;
    mispredict_E = 1'b0;
    br_cond_E    = 1'b0;
    stall_F      = 1'b0;
    flush_D      = 1'b0;
    opcode_E     = OP_REG;
  endtask

  task automatic upd(input opcode_t op, input logic [31:0] pce, input logic [31:0] tgt,
                     input logic cond, input logic misp, input logic [1:0] cn);
    upd_valid_E   = 1'b1;
    opcode_E      = op;
    pc_E          = pce;
    target_addr_E = tgt;
    br_cond_E     = cond;
    mispredict_E  = misp;
    ctr_next_E    = cn;
  endtask

  initial begin
    rst_l = 1'b0; pc_F = 32'h100; pc_E = '0; target_addr_E = '0; ctr_next_E = '0;
    stall_F = 1'b0; flush_D = 1'b0; upd_valid_E = 1'b0; br_cond_E = 1'b0;
    mispredict_E = 1'b0; opcode_E = OP_REG;

    tick(); exp_now(S_NPC, 32'h104, "npc_in_reset"); exp_now(S_CTRL, 0, "nctrl_reset");
    exp_now(S_TAKD, 0, "takD_reset");
    tick(); rst_l = 1'b1; pc_F = 32'h100;
    exp_now(S_NPC, 32'h104, "t1_npc"); exp_now(S_MIS, 0, "nmis_reset");
    exp_next(S_TAKD, 0, "t1_takD"); exp_next(S_CTRD, 0, "t1_ctrD");

    // JAL mispredict allocates and redirects
    tick(); upd(OP_JAL, 32'h200, 32'h400, 1'b0, 1'b1, 2'b11);
    exp_now(S_NPC, 32'h400, "t2_redirect"); exp_next(S_TAKD, 0, "t2_redirect_takD");
    tick(); pc_F = 32'h200;
    exp_now(S_NPC, 32'h400, "t2_hit"); exp_now(S_CTRL, 1, "t2_nctrl"); exp_now(S_MIS, 1, "t2_nmis");
    exp_next(S_TAKD, 1, "t2_takD"); exp_next(S_CTRD, 3, "t2_ctrD");

    // Not-taken branch miss: no allocation
    tick(); pc_F = 32'h108; upd(OP_BRANCH, 32'h300, 32'h999, 1'b0, 1'b0, 2'b00);
    exp_now(S_NPC, 32'h10C, "t3_seq");
    tick(); pc_F = 32'h300;
    exp_now(S_NPC, 32'h304, "t3_no_alloc"); exp_now(S_CTRL, 2, "t3_nctrl"); exp_now(S_MIS, 1, "t3_nmis");
    exp_next(S_TAKD, 0, "t3_takD"); exp_next(S_CTRD, 0, "t3_ctrD");

    // Non-control update: no write, counters untouched
    tick(); pc_F = 32'h108; upd(OP_REG, 32'h600, 32'h900, 1'b1, 1'b0, 2'b11);
    tick(); pc_F = 32'h600;
    exp_now(S_NPC, 32'h604, "nonctrl_no_write"); exp_now(S_CTRL, 2, "nonctrl_nctrl");

    // Strong-taken entry resolves not-taken
    tick(); pc_F = 32'h108; upd(OP_BRANCH, 32'h500, 32'h700, 1'b1, 1'b0, 2'b11);
    tick(); pc_F = 32'h500;
    exp_now(S_NPC, 32'h700, "t4_alloc_hit"); exp_now(S_CTRL, 3, "t4_nctrl");
    exp_next(S_TAKD, 1, "t4_takD"); exp_next(S_CTRD, 3, "t4_ctrD");
    tick(); pc_F = 32'h500; upd(OP_BRANCH, 32'h500, 32'h700, 1'b0, 1'b1, 2'b10);
    exp_now(S_NPC, 32'h504, "t4_redirect_nt");
    exp_next(S_TAKD, 0, "t4_clr_takD"); exp_next(S_CTRD, 0, "t4_clr_ctrD");
    tick(); pc_F = 32'h500;
    exp_now(S_NPC, 32'h700, "t4_still_taken"); exp_now(S_CTRL, 4, "t4_nctrl2"); exp_now(S_MIS, 2, "t4_nmis");
    exp_next(S_TAKD, 1, "t4_weak_takD"); exp_next(S_CTRD, 2, "t4_weak_ctrD");

    // Aliasing 0x040 / 0x140 plus same-cycle lookup of the index being written
    tick(); pc_F = 32'h108; upd(OP_JAL, 32'h040, 32'h800, 1'b0, 1'b0, 2'b11);
    tick(); pc_F = 32'h040; exp_now(S_NPC, 32'h800, "t5_first_hit");
    tick(); pc_F = 32'h040; upd(OP_JAL, 32'h140, 32'h900, 1'b0, 1'b0, 2'b10);
    exp_now(S_NPC, 32'h800, "t6_same_cycle_old"); exp_next(S_CTRD, 3, "t6_old_ctrD");
    tick(); pc_F = 32'h040;
    exp_now(S_NPC, 32'h044, "t5_evicted"); exp_now(S_CTRL, 6, "t5_nctrl");
    exp_next(S_TAKD, 0, "t5_evicted_takD");

    // Stall holds D, flush beats stall
    tick(); pc_F = 32'h140;
    exp_now(S_NPC, 32'h900, "t5_alias_hit"); exp_next(S_TAKD, 1, "pre_stall_takD"); exp_next(S_CTRD, 2, "pre_stall_ctrD");
    tick(); pc_F = 32'h104; stall_F = 1'b1;
    exp_next(S_TAKD, 1, "stall_hold_takD"); exp_next(S_CTRD, 2, "stall_hold_ctrD");
    tick(); pc_F = 32'h500; stall_F = 1'b1; flush_D = 1'b1;
    exp_next(S_TAKD, 0, "flush_over_stall_takD"); exp_next(S_CTRD, 0, "flush_over_stall_ctrD");
    tick(); pc_F = 32'h500;
    exp_now(S_NPC, 32'h700, "post_flush_npc"); exp_next(S_CTRD, 2, "post_flush_ctrD");

    // Perf counter saturation: 6+14 ctrl, 2+14 mispredicts, 4-bit counters
    for (int k = 0; k < 14; k++) begin
      tick(); pc_F = 32'h104; upd(OP_JAL, 32'h200, 32'h400, 1'b0, 1'b1, 2'b11);
      if (k == 0) exp_now(S_NPC, 32'h400, "sat_redirect");
    end
    tick(); pc_F = 32'h104;
    exp_now(S_CTRL, 15, "nctrl_saturate"); exp_now(S_MIS, 15, "nmis_saturate");

    // Reset asserted during an allocating update: write lost
    tick(); pc_F = 32'h280; upd(OP_JAL, 32'h280, 32'hA00, 1'b0, 1'b0, 2'b11); rst_l = 1'b0;
    exp_now(S_NPC, 32'h284, "reset_npc"); exp_now(S_CTRL, 0, "reset_async_nctrl");
    tick(); rst_l = 1'b1; pc_F = 32'h280;
    exp_now(S_NPC, 32'h284, "reset_write_lost"); exp_now(S_MIS, 0, "reset_nmis");
    tick(); pc_F = 32'h140;
    exp_now(S_NPC, 32'h144, "reset_invalidates");

    tick(); tick(); tick();
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
